// File: rtl/mat_pkg.sv
// Shared definitions for the matrix coprocessor datapath blocks:
// element-operation encodings, stream FSM states and default geometry.
package mat_pkg;

    // Default matrix geometry and element width.
    localparam int DEF_EW   = 8;
    localparam int DEF_COLS = 5;
    localparam int DEF_ROWS = 5;

    // Element-wise unary operation, selected once per matrix.
    typedef enum logic [1:0] {
        OPP_NEG_WRAP = 2'b00,
        OPP_NEG_SAT  = 2'b01,
        OPP_ABS_SAT  = 2'b10,
        OPP_PASS     = 2'b11
    } opp_mode_e;

    // Matrix stream control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } opp_state_e;

    // A MIN element only counts as an overflow when the operation
    // actually has to negate it.
    function automatic logic mode_can_ovf(input logic [1:0] m);
        return (m != OPP_PASS);
    endfunction

endpackage

// File: rtl/opp_elem.sv
// Single-element unary operation: wrapping negate, saturating negate,
// saturating absolute value or pass-through on a signed EW-bit value.
// Purely combinational; the caller decides whether is_min is an overflow.
module opp_elem
    import mat_pkg::*;
#(
    parameter int EW = DEF_EW
) (
    input  logic [EW-1:0] x,
    input  logic [1:0]    mode,
    output logic [EW-1:0] y,
    output logic          is_min
);

    localparam logic [EW-1:0] MIN_V = {1'b1, {(EW-1){1'b0}}};
    localparam logic [EW-1:0] MAX_V = {1'b0, {(EW-1){1'b1}}};

    logic [EW-1:0] neg;

    // Two's complement negate; MIN maps onto itself, which is exactly
    // the wrapping behaviour and is overridden for the saturating modes.
    always_comb begin
        neg    = -x;
        is_min = (x == MIN_V);
    end

    // Select the result for the latched operation.
    always_comb begin
        y = x;
        case (opp_mode_e'(mode))
            OPP_NEG_WRAP: y = neg;
            OPP_NEG_SAT:  y = is_min ? MAX_V : neg;
            OPP_ABS_SAT:  y = is_min ? MAX_V : (x[EW-1] ? neg : x);
            default:      y = x;
        endcase
    end

endmodule

// File: rtl/opp_matrix_stream.sv
// Streaming matrix unary-operation unit. Rows arrive over a valid/ready
// input, each element is transformed by the operation latched at start,
// and the result row is held in a single output register until taken.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high; valid never depends on ready, and the
// presented data holds stable while valid is high and ready is low.
module opp_matrix_stream
    import mat_pkg::*;
#(
    parameter int EW   = DEF_EW,
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COLS*EW-1:0]   in_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLS*EW-1:0]   out_row,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int RW = COLS * EW;
    localparam int CW = $clog2(ROWS + 1);

    localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
    localparam logic [CW-1:0] LAST_C = CW'(ROWS - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    opp_state_e      state_q, state_d;
    opp_mode_e       mode_q, mode_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [RW-1:0]   out_row_q, out_row_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            ovf_q, ovf_d;

    logic [RW-1:0]   res_row;
    logic [COLS-1:0] min_vec;
    logic            in_ready_w;
    logic            in_fire;
    logic            out_fire;
    logic            row_ovf;

    // One element unit per column, element 0 in the most significant slot.
    for (genvar g = 0; g < COLS; g++) begin : g_elem
        opp_elem #(
            .EW (EW)
        ) u_elem (
            .x      (in_row[(COLS-g)*EW-1 -: EW]),
            .mode   (mode_q),
            .y      (res_row[(COLS-g)*EW-1 -: EW]),
            .is_min (min_vec[g])
        );
    end

    // Accept a row only while running, while rows remain, and when the
    // output register is empty or is being emptied this cycle.
    always_comb begin
        in_ready_w = (state_q == ST_RUN) && (in_cnt_q < ROWS_C)
                     && (!out_valid_q || out_ready);
        in_fire    = in_valid && in_ready_w;
        out_fire   = out_valid_q && out_ready;
        row_ovf    = mode_can_ovf(mode_q) && (|min_vec);
    end

    // Next-state logic for the FSM, counters, output register and ovf.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        out_row_d   = out_row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    mode_d      = opp_mode_e'(mode);
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            ST_RUN: begin
                // Drain first; a load in the same cycle overrides the clear
                // so back-to-back rows stream without a bubble.
                if (out_fire) begin
                    out_cnt_d   = out_cnt_q + ONE_C;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_DONE;
                    end
                end
                if (in_fire) begin
                    out_row_d   = res_row;
                    out_valid_d = 1'b1;
                    out_last_d  = (in_cnt_q == LAST_C);
                    in_cnt_d    = in_cnt_q + ONE_C;
                    if (row_ovf) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset discards any
    // pending row and suppresses the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= OPP_NEG_WRAP;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
        end
    end

    // Outputs come straight from registers (in_ready excepted, which must
    // follow out_ready combinationally to allow zero-bubble streaming).
    always_comb begin
        in_ready  = in_ready_w;
        out_valid = out_valid_q;
        out_row   = out_row_q;
        out_last  = out_last_q;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_opp_matrix_stream.sv
// Bench for opp_matrix_stream: directed steps plus randomized matrices,
// with a negedge scoreboard fed by a behavioural model of the operations.
module tb_opp_matrix_stream;

    localparam int EW   = 8;
    localparam int COLS = 5;
    localparam int ROWS = 3;
    localparam int RW   = COLS * EW;
    localparam int W    = RW + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_row;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {last, row} per accepted input, in order.
    logic [W-1:0] exp_q[$];
    logic [1:0]   mode_m;
    int           in_idx;
    int           acc_cnt;
    int           done_cnt;
    bit           done_due;
    bit           ovf_m;

    opp_matrix_stream #(
        .EW   (EW),
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model: arithmetic on plain signed integers.
    function automatic logic [EW-1:0] ref_elem(input logic [1:0] m, input logic [EW-1:0] x);
        int v;
        int r;
        int maxv;
        maxv = (1 << (EW - 1)) - 1;
        v = int'($signed(x));
        case (m)
            2'b00: begin r = -v; if (r > maxv) r = r - (1 << EW); end
            2'b01: begin r = -v; if (r > maxv) r = maxv; end
            2'b10: begin r = (v < 0) ? -v : v; if (r > maxv) r = maxv; end
            default: r = v;
        endcase
        return r[EW-1:0];
    endfunction

    function automatic logic [RW-1:0] ref_row(input logic [1:0] m, input logic [RW-1:0] row);
        logic [RW-1:0] res;
        res = '0;
        for (int i = 0; i < COLS; i++)
            res[(COLS-i)*EW-1 -: EW] = ref_elem(m, row[(COLS-i)*EW-1 -: EW]);
        return res;
    endfunction

    function automatic bit row_has_min(input logic [RW-1:0] row);
        logic [EW-1:0] minv;
        minv = {1'b1, {(EW-1){1'b0}}};
        for (int i = 0; i < COLS; i++)
            if (row[(COLS-i)*EW-1 -: EW] == minv) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [RW-1:0] rand_row(input bit allow_min);
        logic [RW-1:0] row;
        logic [EW-1:0] e;
        for (int i = 0; i < COLS; i++) begin
            e = EW'($urandom_range(0, (1 << EW) - 1));
            if (allow_min && $urandom_range(0, 5) == 0) e = {1'b1, {(EW-1){1'b0}}};
            if (!allow_min && e == {1'b1, {(EW-1){1'b0}}}) e = e + 1'b1;
            row[(COLS-i)*EW-1 -: EW] = e;
        end
        return row;
    endfunction

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst) begin
            exp_q.delete();
            done_due = 1'b0;
            in_idx   = 0;
            ovf_m    = 1'b0;
        end else begin
            chk("done_pulse", 64'(done), 64'(done_due));
            if (done_due) chk("ovf_at_done", 64'(ovf), 64'(ovf_m));
            done_due = 1'b0;
            if (start && !busy) begin
                mode_m  = mode;
                in_idx  = 0;
                acc_cnt = 0;
                ovf_m   = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("sb_has_row", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("out_row", 64'(out_row), 64'(e[RW-1:0]));
                    chk("out_last", 64'(out_last), 64'(e[W-1]));
                    if (out_last) done_due = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({(in_idx == ROWS - 1), ref_row(mode_m, in_row)});
                if (mode_m != 2'b11 && row_has_min(in_row)) ovf_m = 1'b1;
                in_idx++;
                acc_cnt++;
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_matrix(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
    endtask

    task automatic send_row(input logic [RW-1:0] row, input bit rand_ready);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_row   = row;
        for (int t = 0; t < 100; t++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        chk("row_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_done(input bit rand_ready);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            step();
            chk("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_row"},   64'(out_row),   64'd0);
        chk({tag, "_out_last"},  64'(out_last),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
        chk({tag, "_ovf"},       64'(ovf),       64'd0);
    endtask

    logic [EW-1:0] min_exp [4];
    logic [RW-1:0] row_b;
    int            dc0;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b1;
        mode_m    = 2'b00;
        in_idx    = 0;
        acc_cnt   = 0;
        done_cnt  = 0;
        done_due  = 1'b0;
        ovf_m     = 1'b0;
        min_exp   = '{8'h80, 8'h7f, 8'h7f, 8'h80};

        // Reset state
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        // NEG_WRAP directed rows
        start_matrix(2'b00);
        out_ready = 1'b1;
        send_row(40'h01fe03fc05, 1'b0);
        chk("negwrap_row0", 64'(out_row), 64'h00ff02fd04fb);
        chk("negwrap_last0", 64'(out_last), 64'd0);
        send_row(40'h007f810af6, 1'b0);
        chk("negwrap_row1", 64'(out_row), 64'h0000817ff60a);
        send_row(rand_row(1'b0), 1'b0);
        chk("negwrap_last2", 64'(out_last), 64'd1);
        wait_done(1'b0);
        chk("negwrap_ovf", 64'(ovf), 64'd0);

        // MIN handling in every mode
        for (int m = 0; m < 4; m++) begin
            start_matrix(2'(m));
            out_ready = 1'b1;
            send_row(40'h8000000000, 1'b0);
            chk("min_row", 64'(out_row), 64'({min_exp[m], 32'h0}));
            chk("min_ovf", 64'(ovf), 64'(m != 3));
            send_row(rand_row(1'b0), 1'b0);
            send_row(rand_row(1'b0), 1'b0);
            wait_done(1'b0);
        end

        // Backpressure with NEG_SAT
        start_matrix(2'b01);
        out_ready = 1'b0;
        send_row(40'h0505050505, 1'b0);
        row_b    = rand_row(1'b0);
        in_valid = 1'b1;
        in_row   = row_b;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_row_stable", 64'(out_row), 64'hfbfbfbfbfb);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_no_bubble_valid", 64'(out_valid), 64'd1);
        chk("bp_no_bubble_row", 64'(out_row), 64'(ref_row(2'b01, row_b)));
        send_row(rand_row(1'b1), 1'b0);
        wait_done(1'b0);

        // Over-supply: in_valid held high beyond ROWS rows
        dc0 = done_cnt;
        start_matrix(2'(($urandom_range(0, 3))));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_row = rand_row(1'b1);
            #1;
            if (acc_cnt == ROWS && busy) chk("over_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("over_accepted", 64'(acc_cnt), 64'(ROWS));
        chk("over_done_pulses", 64'(done_cnt - dc0), 64'd1);

        // Reset mid-matrix
        start_matrix(2'b00);
        out_ready = 1'b1;
        send_row(rand_row(1'b1), 1'b0);
        send_row(40'h8000000000, 1'b0);
        rst = 1'b1;
        step();
        check_reset_vals("midrst");
        rst = 1'b0;
        step();
        start_matrix(2'b10);
        send_row(40'hfdfdfdfdfd, 1'b0);
        chk("abs_row", 64'(out_row), 64'h0303030303);
        chk("abs_ovf", 64'(ovf), 64'd0);
        send_row(rand_row(1'b0), 1'b0);
        send_row(rand_row(1'b0), 1'b0);
        wait_done(1'b0);

        // start during RUN with a different mode is ignored
        start_matrix(2'b01);
        out_ready = 1'b1;
        send_row(rand_row(1'b0), 1'b0);
        start = 1'b1;
        mode  = 2'b11;
        send_row(40'h8001020304, 1'b0);
        start = 1'b0;
        chk("ignored_start_row", 64'(out_row), 64'h7ffffefdfc);
        chk("ignored_start_ovf", 64'(ovf), 64'd1);
        send_row(rand_row(1'b1), 1'b0);
        wait_done(1'b0);

        // Randomized matrices with random backpressure and gaps
        for (int n = 0; n < 15; n++) begin
            start_matrix(2'($urandom_range(0, 3)));
            for (int r = 0; r < ROWS; r++) begin
                repeat ($urandom_range(0, 2)) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                end
                send_row(rand_row(1'b1), 1'b1);
            end
            wait_done(1'b1);
        end

        step();
        step();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opp_matrix_stream.md
# opp_matrix_stream

Streaming, parametrised successor to the coprocessor's single-row opposite unit. It accepts a whole matrix row by row over a valid/ready handshake and applies a per-matrix selected element-wise unary operation: wrapping negate, saturating negate, saturating absolute value, or pass-through. It registers each result row, marks the last row, and reports a sticky overflow flag for the matrix. It sits between the row-fetch logic and the result write-back in the coprocessor datapath.

## Interface
Parameters:
- `EW`, 8, element width in bits (signed two's complement).
- `COLS`, 5, elements per row.
- `ROWS`, 5, rows per matrix (≥1).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle pulse; begins a matrix; sampled only in IDLE.
- `mode`  in  2  operation, latched on accepted `start`: 00 NEG_WRAP, 01 NEG_SAT, 10 ABS_SAT, 11 PASS.
- `in_valid`  in  1  `in_row` valid.
- `in_ready`  out  1  block accepts `in_row` this cycle.
- `in_row`  in  COLS*EW  packed row; element 0 at MSBs `[COLS*EW-1 -: EW]`, element i at `[(COLS-i)*EW-1 -: EW]`.
- `out_valid`  out  1  `out_row` valid.
- `out_ready`  in  1  downstream accepts `out_row`.
- `out_row`  out  COLS*EW  result row, same packing.
- `out_last`  out  1  qualifies `out_row` as row ROWS-1.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse after last row handed off.
- `ovf`  out  1  sticky: some element of current matrix was −2^(EW−1) under NEG_WRAP/NEG_SAT/ABS_SAT.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. Latch `mode`, clear `in_cnt`, `out_cnt`, `ovf`.
  - RUN → DONE when the output handshake with `out_last`=1 completes.
  - DONE → IDLE unconditionally after one cycle. `done`=1 only in DONE.
- `start` while in RUN or DONE is ignored. `mode` changes after latch have no effect.
- `in_ready` = RUN && `in_cnt` < ROWS && (!`out_valid` || `out_ready`).
- Input handshake (`in_valid` && `in_ready`): compute all COLS elements, load the output register, set `out_valid`, increment `in_cnt`. `out_last` = (`in_cnt` == ROWS−1).
- Output handshake (`out_valid` && `out_ready`): increment `out_cnt`. If no new row loads in the same cycle, clear `out_valid`. Simultaneous output and input handshakes replace the register with no bubble.
- `out_row`/`out_last` hold stable while `out_valid` && !`out_ready`.
- Element arithmetic, with x = element and MIN = −2^(EW−1), MAX = 2^(EW−1)−1, results EW bits:
  - NEG_WRAP: −x mod 2^EW. MIN→MIN.
  - NEG_SAT: −x. MIN→MAX.
  - ABS_SAT: |x|. MIN→MAX.
  - PASS: x. Never sets `ovf`.
- `ovf` is set on the input handshake if any element equals MIN in a non-PASS mode. It holds until the next accepted `start` or `rst`.

## Timing
- Latency: 1 cycle from input handshake to `out_valid`. Throughput: 1 row/cycle with `out_ready` held high.
- Reset values: `in_ready`=0, `out_valid`=0, `out_row`=0, `out_last`=0, `busy`=0, `done`=0, `ovf`=0, state IDLE, counters 0.
- `rst` mid-matrix: the next cycle shows all reset values. Any pending row is discarded and no `done` is produced.
- `done` asserts the cycle after the final output handshake. `busy` drops the cycle after that.
- Once `in_cnt`==ROWS, `in_ready` stays 0 and extra input rows are not consumed.

## Structure
- Shared package `mat_pkg`: mode encodings (`OPP_NEG_WRAP`, `OPP_NEG_SAT`, `OPP_ABS_SAT`, `OPP_PASS`), FSM state encodings, default EW/COLS/ROWS.
- Sub-module `opp_elem` (combinational, EW parameter): x, mode → y, `is_min`. Instantiated COLS times by generate.
- The top level holds the FSM, counters (width $clog2(ROWS+1)), output register and `ovf`.

## Test plan
- NEG_WRAP, EW=8, COLS=5, ROWS=2, rows {1,−2,3,−4,5},{0,127,−127,10,−10}, `out_ready`=1 → outputs {−1,2,−3,4,−5},{0,−127,127,−10,10}. `out_last` on row 2, `done` one cycle later, `ovf`=0.
- MIN handling: row {−128,0,0,0,0} in NEG_WRAP → −128 with `ovf`=1. In NEG_SAT → 127 with `ovf`=1. In ABS_SAT → 127 with `ovf`=1. In PASS → −128 with `ovf`=0.
- Backpressure: hold `out_ready`=0 for 3 cycles with the row {5,5,5,5,5} in NEG_SAT → `out_row`={−5,…} stable and `in_ready`=0. Release → handshake occurs, next row accepted the same cycle.
- Over-supply: ROWS=3, `in_valid` held high for 5 rows → exactly 3 rows accepted, `in_ready`=0 afterwards, one `done` pulse.
- Reset mid-matrix: after 2 of 5 rows, assert `rst` → all outputs at reset values next cycle. A new `start` with ABS_SAT on {−3,…} → 3 and `ovf`=0.
- `start` pulsed during RUN with a different `mode` → ignored; latched mode is kept for all rows.
